// File: rtl/la_word_serializer.sv
// Framed parallel-to-serial transmitter: start bit, LSB-first payload, optional even parity, stop bit.
// Optional parity bit is enabled by defining LA_SER_PARITY_EN.
module la_word_serializer #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DIV   = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic             ser_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = $clog2(WIDTH + 1);

    if (DIV == 0) begin : g_div_check
        $fatal(1, "la_word_serializer: DIV must be at least 1");
    end

`ifdef LA_SER_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             ser_q, ser_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_tick;
`ifdef LA_SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ser_q     <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef LA_SER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ser_q     <= ser_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef LA_SER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef LA_SER_PARITY_EN
        parity_d  = parity_q;
`endif
        ser_d     = 1'b1;
        ready_d   = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;

        // Divider is the single bit-timing source; it runs only while a frame is active.
        bit_tick = (div_cnt_q == DIV_W'(DIV - 1));
        if (state_q != IDLE) begin
            div_cnt_d = bit_tick ? '0 : div_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tx_valid_i && ready_q) begin
                    state_d   = START;
                    shift_d   = tx_data_i;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
`ifdef LA_SER_PARITY_EN
                    parity_d  = ^tx_data_i;
`endif
                end
            end
            START: begin
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                        bit_cnt_d = '0;
`ifdef LA_SER_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef LA_SER_PARITY_EN
            PARITY: begin
                if (bit_tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        case (state_d)
            IDLE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                done_d  = (state_q == STOP);
            end
            START:   ser_d = 1'b0;
            DATA:    ser_d = shift_d[0];
`ifdef LA_SER_PARITY_EN
            PARITY:  ser_d = parity_q;
`endif
            STOP:    ser_d = 1'b1;
            default: ser_d = 1'b1;
        endcase
    end

    assign tx_ready_o = ready_q;
    assign ser_o      = ser_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_la_word_serializer.sv
// Bench for la_word_serializer: frame-level model plus directed literal checks on two instances
// (WIDTH=8 with DIV=2 and DIV=1).
module tb_la_word_serializer;

`ifdef LA_SER_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid [2];
    logic [7:0] data  [2];
    logic       ser   [2];
    logic       rdy   [2];
    logic       busy  [2];
    logic       done  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    la_word_serializer #(.WIDTH(8), .DIV(2)) u_dut_div2 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .tx_data_i(data[0]), .tx_valid_i(valid[0]),
        .tx_ready_o(rdy[0]), .ser_o(ser[0]), .busy_o(busy[0]), .done_o(done[0])
    );

    la_word_serializer #(.WIDTH(8), .DIV(1)) u_dut_div1 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .tx_data_i(data[1]), .tx_valid_i(valid[1]),
        .tx_ready_o(rdy[1]), .ser_o(ser[1]), .busy_o(busy[1]), .done_o(done[1])
    );

    task automatic check(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Model: each accepted word becomes a queue of line levels, one entry per clock.
    logic mq [2][$];
    logic m_ser [2], m_busy [2], m_ready [2], m_done [2];

    function automatic void push_frame(input int i, input logic [7:0] d);
        int   div = (i == 0) ? 2 : 1;
        logic b[$];
        b.push_back(1'b0);
        for (int j = 0; j < 8; j++) b.push_back(d[j]);
`ifdef LA_SER_PARITY_EN
        b.push_back(^d);
`endif
        b.push_back(1'b1);
        foreach (b[j]) repeat (div) mq[i].push_back(b[j]);
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mq[i].delete();
                m_ser[i] = 1'b1; m_busy[i] = 1'b0; m_ready[i] = 1'b1; m_done[i] = 1'b0;
            end
            check($sformatf("ser%0d", i),   ser[i],  m_ser[i]);
            check($sformatf("busy%0d", i),  busy[i], m_busy[i]);
            check($sformatf("ready%0d", i), rdy[i],  m_ready[i]);
            check($sformatf("done%0d", i),  done[i], m_done[i]);
            if (rst_n) begin
                if (mq[i].size() == 0 && m_ready[i] && valid[i]) push_frame(i, data[i]);
                if (mq[i].size() > 0) begin
                    m_ser[i] = mq[i].pop_front();
                    m_busy[i] = 1'b1; m_ready[i] = 1'b0; m_done[i] = 1'b0;
                end else begin
                    m_done[i]  = m_busy[i];
                    m_ser[i]   = 1'b1; m_busy[i] = 1'b0; m_ready[i] = 1'b1;
                end
            end
        end
    end

    logic sb [0:63], db [0:63], bb [0:63], rb [0:63];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one word in the current cycle (cycle 0), then records cycles 1..n.
    task automatic run_frame(input int inst, input logic [7:0] d, input int n);
        valid[inst] = 1'b1; data[inst] = d;
        step(1);
        valid[inst] = 1'b0; data[inst] = ~d;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            sb[k] = ser[inst]; db[k] = done[inst]; bb[k] = busy[inst]; rb[k] = rdy[inst];
        end
        step(1);
    endtask

    logic [0:19] exp_a5;

    initial begin
        rst_n = 1'b0;
        valid[0] = 1'b0; valid[1] = 1'b0;
        data[0] = 8'h00; data[1] = 8'h00;
        exp_a5 = 20'b00110011000011001111;

        // Reset values held and kept after release
        step(3);
        for (int i = 0; i < 2; i++) begin
            check("rst_ser", ser[i], 1'b1);   check("rst_ready", rdy[i], 1'b1);
            check("rst_busy", busy[i], 1'b0); check("rst_done", done[i], 1'b0);
        end
        rst_n = 1'b1;
        step(2);
        check("post_rst_ser", ser[0], 1'b1);
        check("post_rst_busy", busy[0], 1'b0);

`ifndef LA_SER_PARITY_EN
        // Basic 0xA5 frame at DIV=2
        run_frame(0, 8'hA5, 21);
        for (int k = 1; k <= 20; k++) check($sformatf("a5_bit_c%0d", k), sb[k], exp_a5[k-1]);
        check("a5_done_c20", db[20], 1'b0);
        check("a5_done_c21", db[21], 1'b1);
        check("a5_busy_c1",  bb[1],  1'b1);
        check("a5_busy_c20", bb[20], 1'b1);
        check("a5_busy_c21", bb[21], 1'b0);
`else
        run_frame(0, 8'h01, 23);
        check("p01_par_c19",  sb[19], 1'b1);
        check("p01_par_c20",  sb[20], 1'b1);
        check("p01_stop_c22", sb[22], 1'b1);
        check("p01_done_c22", db[22], 1'b0);
        check("p01_done_c23", db[23], 1'b1);
        run_frame(0, 8'hA5, 23);
        check("pa5_par_c19", sb[19], 1'b0);
        check("pa5_par_c20", sb[20], 1'b0);
`endif

        // Word offered while busy is held off until the done cycle
        valid[0] = 1'b1; data[0] = 8'h5A;
        step(1);
        valid[0] = 1'b0;
        step(6);
        valid[0] = 1'b1; data[0] = 8'hFF;
        @(negedge clk);
        check("busy_ign_ready", rdy[0], 1'b0);
        check("busy_ign_busy",  busy[0], 1'b1);
        step(2 * FB + 1 - 7);
        @(negedge clk);
        check("busy_ign_done",  done[0], 1'b1);
        check("busy_ign_rdy_d", rdy[0], 1'b1);
        step(1);
        valid[0] = 1'b0;
        @(negedge clk);
        check("busy_ign_start", ser[0], 1'b0);
        check("busy_ign_busy2", busy[0], 1'b1);
        step(2 * FB + 2);

        // Back-to-back at DIV=1 with tx_data_i scrambled during the second frame
        valid[1] = 1'b1; data[1] = 8'h3C;
        step(1);
        data[1] = 8'hC3;
        for (int c = 1; c <= 2 * FB + 3; c++) begin
            if (c >= FB + 2) begin
                valid[1] = 1'b0;
                data[1]  = 8'($urandom);
            end
            @(negedge clk);
            sb[c] = ser[1]; db[c] = done[1]; rb[c] = rdy[1];
            step(1);
        end
        check("b2b_f1_bit0",  sb[2], 1'b0);
        check("b2b_f1_bit2",  sb[4], 1'b1);
        check("b2b_stop",     sb[FB], 1'b1);
        check("b2b_gap_ser",  sb[FB+1], 1'b1);
        check("b2b_done1",    db[FB+1], 1'b1);
        check("b2b_gap_rdy",  rb[FB+1], 1'b1);
        check("b2b_start2",   sb[FB+2], 1'b0);
        check("b2b_f2_bit0",  sb[FB+3], 1'b1);
        check("b2b_f2_bit2",  sb[FB+5], 1'b0);
        check("b2b_done2",    db[2*FB+2], 1'b1);

        // Reset during data bit 4 aborts the frame
        valid[0] = 1'b1; data[0] = 8'h69;
        step(1);
        valid[0] = 1'b0;
        step(10);
        @(negedge clk);
        check("abort_bit4", ser[0], 1'b0);
        step(1);
        rst_n = 1'b0;
        #1;
        check("abort_ser",  ser[0], 1'b1);
        check("abort_busy", busy[0], 1'b0);
        check("abort_done", done[0], 1'b0);
        step(2);
        rst_n = 1'b1;
        step(3);
        run_frame(0, 8'h3C, 2 * FB + 2);
        check("after_abort_bit0", sb[3], 1'b0);
        check("after_abort_bit2", sb[7], 1'b1);
        check("after_abort_done", db[2*FB+1], 1'b1);
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
